// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state enum and parameter defaults for the data-memory arbiter
package dmem_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_e;
  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;
  localparam int DEF_MAX_WAIT = 4;
  localparam int DEF_BURST_LEN = 4;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: core, host and DMem buses; slave is the arbiter side, master the environment
interface dmem_arbiter_if import dmem_arb_pkg::*; #(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);
  logic core_en, core_mreq, core_wen, core_stall;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdat, core_rdat;
  logic host_req, host_we, host_burst, host_gnt, host_rvalid;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdat, host_rdata;
  logic mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdat, mem_rdat;
  modport slave (
    input core_en, core_mreq, core_wen, core_addr, core_wdat,
    input host_req, host_we, host_burst, host_addr, host_wdat, mem_rdat,
    output core_rdat, core_stall, host_gnt, host_rvalid, host_rdata,
    output mem_wen, mem_addr, mem_wdat
  );
  modport master (
    output core_en, core_mreq, core_wen, core_addr, core_wdat,
    output host_req, host_we, host_burst, host_addr, host_wdat, mem_rdat,
    input core_rdat, core_stall, host_gnt, host_rvalid, host_rdata,
    input mem_wen, mem_addr, mem_wdat
  );
endinterface

// File: rtl/dmem_burst_seq.sv
// dmem_burst_seq: BURST state and beat counter; beat 0 is the granting IDLE cycle
module dmem_burst_seq import dmem_arb_pkg::*; #(
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       active,
  output logic [2:0] beat
);
  arb_state_e state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic last;
  assign last = cnt == 3'(BURST_LEN - 1);
  always_ff @(posedge clk) begin
    state <= !reset ? ARB_IDLE : state_nx;
    cnt <= !reset ? 3'd0 : cnt_nx;
  end
  always_comb begin
    state_nx = state == ARB_BURST ? (last ? ARB_IDLE : ARB_BURST) : (start ? ARB_BURST : ARB_IDLE);
    cnt_nx = state == ARB_BURST ? (last ? 3'd0 : cnt + 3'd1) : {2'b0, start};
  end
  always_comb begin
    active = state == ARB_BURST;
    beat = active ? cnt : 3'd0;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: core-priority DMem arbiter with host starvation guard
// DMEM_ARB_BURST_EN enables multi-beat host bursts
module dmem_arbiter import dmem_arb_pkg::*; #(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int MAX_WAIT = DEF_MAX_WAIT,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input logic clk,
  input logic reset,
  dmem_arbiter_if.slave bus
);
  logic burst_active, gnt, core_acc;
  logic [2:0] beat;
  logic [3:0] wait_cnt;
`ifdef DMEM_ARB_BURST_EN
  dmem_burst_seq #(.BURST_LEN(BURST_LEN)) u_seq (
    .clk(clk),
    .reset(reset),
    .start(gnt & bus.host_burst & !burst_active),
    .active(burst_active),
    .beat(beat)
  );
`else
  logic unused_burst;
  assign burst_active = 1'b0;
  assign beat = 3'd0;
  assign unused_burst = ^{bus.host_burst, BURST_LEN[0]};
`endif
  assign core_acc = bus.core_en & bus.core_mreq;
  assign gnt = reset & (burst_active | (bus.host_req & (!core_acc | wait_cnt == 4'(MAX_WAIT))));
  assign bus.host_gnt = gnt;
  assign bus.core_stall = core_acc & gnt;
  assign bus.core_rdat = bus.mem_rdat;
  // a granted host takes the whole port, so a stalled core store never reaches memory
  always_comb begin
    bus.mem_wen = reset & (gnt ? bus.host_we : bus.core_wen & core_acc);
    bus.mem_addr = gnt ? bus.host_addr + AW'(beat) : bus.core_addr;
    bus.mem_wdat = gnt ? bus.host_wdat : bus.core_wdat;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt <= 4'd0;
      bus.host_rvalid <= 1'b0;
      bus.host_rdata <= '0;
    end else begin
      wait_cnt <= (gnt | !bus.host_req) ? 4'd0 : (wait_cnt == 4'(MAX_WAIT) ? wait_cnt : wait_cnt + 4'd1);
      bus.host_rvalid <= gnt & !bus.host_we;
      if (gnt & !bus.host_we) bus.host_rdata <= bus.mem_rdat;
    end
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter for the 8-bit data memory. It shares a single DMem port between the processor core and a host port used for test preload and result readback. The core has priority; a starvation counter forces a host slot by stalling the core. The block sits between the core's load/store datapath and DMem, and its `core_stall` output gates the program counter and register-file write.

## Interface
Parameters:
- `AW`, 8, memory address width
- `DW`, 8, memory data width
- `MAX_WAIT`, 4, consecutive denied host cycles before a host slot is forced; range 0..15
- `BURST_LEN`, 4, beats per host burst; range 2..8; used only with the burst macro

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-low reset
- `core_en`  in  1  core running (not done)
- `core_mreq`  in  1  core needs memory this cycle (load or store)
- `core_wen`  in  1  core store
- `core_addr`  in  AW  core address
- `core_wdat`  in  DW  core store data
- `core_rdat`  out  DW  core load data, from `mem_rdat` (combinational)
- `core_stall`  out  1  core must hold PC and suppress RF/DM writes this cycle
- `host_req`  in  1  host access request
- `host_we`  in  1  host write
- `host_burst`  in  1  request burst; ignored without the burst macro
- `host_addr`  in  AW  host address (burst base address)
- `host_wdat`  in  DW  host write data for the current beat
- `host_gnt`  out  1  host owns memory this cycle (combinational)
- `host_rvalid`  out  1  registered host read data valid
- `host_rdata`  out  DW  registered host read data
- `mem_wen`  out  1  DMem write enable
- `mem_addr`  out  AW  DMem address
- `mem_wdat`  out  DW  DMem write data
- `mem_rdat`  in  DW  DMem read data (asynchronous read)

## Operation
- Grant rule, outside a burst: `host_gnt = host_req & (!core_en | !core_mreq | wait_cnt == MAX_WAIT)`.
- `core_stall = core_en & core_mreq & host_gnt`. A stalled core re-executes the same instruction in the next cycle.
- Memory mux:
  - `host_gnt` = 1: memory driven by the host; `mem_wen = host_we`.
  - Otherwise: memory driven by the core; `mem_wen = core_wen & core_en & core_mreq`.
  - `mem_wen` is never asserted for both requesters in one cycle.
- `wait_cnt` (4-bit):
  - clears on `host_gnt` or on `!host_req`;
  - increments when `host_req & !host_gnt`;
  - saturates at `MAX_WAIT`.
  - With `MAX_WAIT` = 0, the host always wins.
- Host read: on a granted cycle with `host_we` = 0, `mem_rdat` is registered into `host_rdata` and `host_rvalid` pulses for one cycle.
- States: IDLE and BURST. BURST is used only with the burst macro; without it the block stays in IDLE permanently.
- Reset state: state IDLE, `wait_cnt` 0, `host_rvalid` 0, `host_rdata` 0. While reset is low, `host_gnt`, `core_stall` and `mem_wen` are forced to 0.

## Timing
- Grant latency: 0 cycles (same cycle as `host_req`). A write commits at the rising edge ending the grant cycle.
- Read latency: 1 cycle (`host_rvalid` in the cycle after the grant).
- Core load data is combinational. A core store commits at the edge of its cycle unless `core_stall` is high.
- Simultaneous core store and starved host: the host wins, the core store is suppressed and retried next cycle, and `wait_cnt` returns to 0.
- `core_en` falling mid-request: the host is granted in the same cycle.
- Reset asserted mid-burst: the burst aborts at that edge, with no further writes and no `host_rvalid`.

## Configuration
- `DMEM_ARB_BURST_EN` defined:
  - A granted request with `host_burst` = 1 enters BURST.
  - For `BURST_LEN` consecutive cycles: `host_gnt` = 1 and `mem_addr = host_addr + beat` (modulo 2^AW, wrapping).
  - The core stalls on any beat where `core_mreq` = 1.
  - `host_req` is ignored during the burst.
  - BURST returns to IDLE after the last beat, with `wait_cnt` 0.
  - Reads produce one `host_rvalid` per beat.
- `DMEM_ARB_BURST_EN` undefined: `host_burst` is ignored and every host grant is a single beat.

## Structure
- Package `dmem_arb_pkg` holds:
  - the state enum (`ARB_IDLE`, `ARB_BURST`);
  - defaults for `AW`, `DW`, `MAX_WAIT` and `BURST_LEN`.
- Sub-module `dmem_burst_seq` holds the beat counter, address offset and BURST state. It is instantiated only under `DMEM_ARB_BURST_EN`.
- The top level holds the grant logic, `wait_cnt`, the muxes and the read register.

## Test plan
- Idle preload: `core_en` = 0, host writes 0x5A to address 0x10, then reads 0x10. Expect `host_gnt` = 1 in both cycles, `mem_wen` = 1 in the write cycle, and `host_rvalid` with `host_rdata` = 0x5A one cycle after the read.
- Core priority: `core_en` = `core_mreq` = 1 every cycle, `host_req` held, `MAX_WAIT` = 4. Expect `host_gnt` = 0 for 4 cycles, then `host_gnt` = `core_stall` = 1 in the 5th, then the pattern repeats.
- Gap steal: `core_mreq` = 0 while `host_req` = 1. Expect immediate grant, `core_stall` = 0, and `wait_cnt` remaining 0.
- Collision: a core store of 0x11 to 0x20 while a starved host writes 0x22 to 0x20. Expect memory 0x20 = 0x22 after that cycle. On the retry cycle the core store proceeds and memory 0x20 = 0x11.
- Burst (macro on): burst read at base 0xFE with `BURST_LEN` = 4. Expect addresses 0xFE, 0xFF, 0x00, 0x01, four `host_rvalid` pulses, and the core stalled on its `mreq` beats.
- Reset mid-burst: `reset` low on beat 2. Expect no `mem_wen` and no `host_rvalid` from the next edge onward, state IDLE, and all outputs 0.
